// File: rtl/jtag_ram_loader.sv
// Scan-chain controller for the JTAG RAM: streams load words into Jin while
// returning the words that fall out of Jout, one shift per accepted word.
module jtag_ram_loader #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             Jen,
  output logic [WIDTH-1:0] Jin,
  input  logic [WIDTH-1:0] Jout,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, FIN} state_t;

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             room;
  logic             fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // A shift only happens when the readback buffer can take the word leaving Jout.
  always_comb begin
    room        = ~out_valid_q | out_ready;
    fire        = (state_q == SHIFT) & ~abort & in_valid & room;
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (fire) begin
      out_data_d  = Jout;
      out_valid_d = 1'b1;
      count_d     = count_q + 1'b1;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (fire && count_q == LAST) begin
          state_d = DRAIN;
        end
      end
      // Hold off the done pulse until the final readback word is taken.
      DRAIN: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (room) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == SHIFT) & ~abort & room;
  assign Jen       = fire;
  assign Jin       = in_data;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == SHIFT) | (state_q == DRAIN);
  assign done      = (state_q == FIN);
  assign count     = count_q;

endmodule

// File: tb/tb_jtag_ram_loader.sv
// Bench for jtag_ram_loader: a scan-chain RAM stand-in plus a queue-based
// model of the chain and readback buffer, checked every cycle.
module tb_jtag_ram_loader;
  localparam int DEPTH = 64;
  localparam int WIDTH = 32;
  localparam int CW    = 7;

  logic             clk = 0;
  logic             reset = 0;
  logic             start = 0;
  logic             abort = 0;
  logic             in_valid = 0;
  logic [WIDTH-1:0] in_data = 0;
  logic             out_ready = 0;
  logic             in_ready, out_valid, Jen, busy, done;
  logic [WIDTH-1:0] out_data, Jin, Jout;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] ram [DEPTH];
  logic             doPreload = 0;
  logic             checkEn = 0;

  int assertCount = 0;
  int failCount = 0;

  int               mPhase = 0;
  int               mCount = 0;
  logic             mBufValid = 0;
  logic [WIDTH-1:0] mBufData = 0;
  logic [WIDTH-1:0] mq[$];
  int               jenPulses = 0;
  int               doneCount = 0;
  int               cyc = 0;
  int               firstFireCyc = 0;
  int               lastFireCyc = 0;
  int               doneCyc = 0;
  logic [WIDTH-1:0] rbDut[$];

  jtag_ram_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .Jen(Jen), .Jin(Jin), .Jout(Jout),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // Chain entry 0 is the head (Jin side), entry DEPTH-1 the tail (Jout side).
  assign Jout = ram[DEPTH-1];

  always @(posedge clk) begin
    if (doPreload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hA000_0000 + 32'(i);
    end else if (Jen) begin
      for (int i = DEPTH - 1; i > 0; i--) ram[i] <= ram[i-1];
      ram[0] <= Jin;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the chain is a tail-first queue; each accepted word pops the tail
  // into the one-entry readback buffer and pushes the new word at the head.
  always @(posedge clk) begin
    logic fireM;
    logic hadBuf;
    cyc++;
    if (Jen) begin
      if (jenPulses == 0) firstFireCyc = cyc;
      jenPulses++;
      lastFireCyc = cyc;
    end
    if (done) begin
      doneCount++;
      doneCyc = cyc;
    end
    if (out_valid && out_ready) rbDut.push_back(out_data);
    if (doPreload) begin
      mq.delete();
      for (int i = DEPTH - 1; i >= 0; i--) mq.push_back(32'hA000_0000 + 32'(i));
    end
    if (reset) begin
      mPhase = 0; mCount = 0; mBufValid = 0; mBufData = 0;
    end else begin
      hadBuf = mBufValid;
      fireM  = (mPhase == 1) && !abort && in_valid && (!hadBuf || out_ready);
      if (hadBuf && out_ready) mBufValid = 0;
      if (fireM) begin
        mBufData  = mq.pop_front();
        mq.push_back(in_data);
        mBufValid = 1;
        mCount++;
      end
      case (mPhase)
        0: if (start) begin mPhase = 1; mCount = 0; end
        1: if (abort) begin mPhase = 0; mBufValid = 0; end
           else if (mCount == DEPTH) mPhase = 2;
        2: if (abort) begin mPhase = 0; mBufValid = 0; end
           else if (!hadBuf || out_ready) mPhase = 3;
        default: mPhase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic eReady;
    if (checkEn && !reset) begin
      eReady = (mPhase == 1) && !abort && (!mBufValid || out_ready);
      check("in_ready", 32'(in_ready), 32'(eReady));
      check("Jen", 32'(Jen), 32'(eReady && in_valid));
      check("Jin", Jin, in_data);
      check("out_valid", 32'(out_valid), 32'(mBufValid));
      if (mBufValid) check("out_data", out_data, mBufData);
      check("busy", 32'(busy), 32'(mPhase == 1 || mPhase == 2));
      check("done", 32'(done), 32'(mPhase == 3));
      check("count", 32'(count), 32'(mCount));
    end
  end

  // mode 0: always ready; mode 1: out_ready 1,0,0,1; mode 2: random valid/ready.
  task automatic applyStimulus(input int mode, input int starveAt, input int abortAt,
                               input int resetAt, input int startAt, input logic [31:0] base);
    int  budget = 0;
    int  starve = 0;
    int  idx = 0;
    bit  starved = 0;
    bit  ended = 0;
    bit  doAbort;
    start = 1; in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    while (!ended) begin
      budget++;
      if (budget > 2000) begin
        assertCount++; failCount++;
        $display("[TB] FAIL pass_timeout: got phase %0d expected pass end within 2000 cycles", mPhase);
        break;
      end
      if (starveAt >= 0 && !starved && mCount == starveAt) begin starve = 10; starved = 1; end
      in_valid  = (starve > 0) ? 1'b0 : (mode == 2 ? ($urandom_range(3) != 0) : 1'b1);
      out_ready = (mode == 1) ? (idx % 4 == 0 || idx % 4 == 3) :
                  (mode == 2) ? 1'($urandom_range(1)) : 1'b1;
      in_data   = (base == 0) ? $urandom : base + 32'(mCount);
      start     = (startAt >= 0 && mCount == startAt);
      doAbort   = (abortAt >= 0 && mCount == abortAt && mPhase == 1);
      abort     = doAbort;
      if (resetAt >= 0 && mCount == resetAt && mPhase == 1) begin
        in_valid = 1;
        #2 reset = 1;
        #1;
        check("rst_Jen", 32'(Jen), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        reset = 0; in_valid = 0;
        ended = 1;
      end else begin
        @(posedge clk); #1;
        idx++;
        if (starve > 0) begin
          starve--;
          if (starve == 0) check("starve_count", 32'(count), 32'(starveAt));
        end
        if (doAbort) begin
          abort = 0;
          check("abort_busy", 32'(busy), 0);
          check("abort_out_valid", 32'(out_valid), 0);
          check("abort_count", 32'(count), 32'(abortAt));
          ended = 1;
        end
        if (mPhase == 0) ended = 1;
      end
    end
    in_valid = 0; start = 0; abort = 0;
    @(posedge clk); #1;
  endtask

  task automatic checkOutput(input string name, input int jen0, input int done0, input int rb0);
    check({name, "_jen"}, 32'(jenPulses - jen0), DEPTH);
    check({name, "_done"}, 32'(doneCount - done0), 1);
    check({name, "_readback"}, 32'(rbDut.size() - rb0), DEPTH);
    check({name, "_count"}, 32'(count), DEPTH);
  endtask

  initial begin
    int j0, d0, r0;
    bit imageOk;
    #1 reset = 1;
    #2;
    check("reset_in_ready", 32'(in_ready), 0);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_data", out_data, 0);
    check("reset_Jen", 32'(Jen), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_count", 32'(count), 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    checkEn = 1;
    doPreload = 1;
    @(posedge clk); #1;
    doPreload = 0;

    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("idle_abort_busy", 32'(busy), 0);

    j0 = jenPulses; d0 = doneCount; r0 = rbDut.size();
    applyStimulus(0, -1, -1, -1, -1, 32'h5000_0000);
    checkOutput("pass1", j0, d0, r0);
    check("pass1_consecutive", 32'(lastFireCyc - firstFireCyc), DEPTH - 1);
    check("pass1_done_latency", 32'(doneCyc - lastFireCyc), 2);
    check("pass1_first_rb", rbDut[r0], 32'hA000_003F);
    check("pass1_last_rb", rbDut[r0 + DEPTH - 1], 32'hA000_0000);
    check("pass1_tail_entry", ram[DEPTH-1], 32'h5000_0000);
    check("pass1_head_entry", ram[0], 32'h5000_003F);

    j0 = jenPulses; d0 = doneCount; r0 = rbDut.size();
    applyStimulus(1, -1, -1, -1, -1, 32'h0);
    checkOutput("backpressure", j0, d0, r0);
    imageOk = 1;
    for (int k = 0; k < DEPTH; k++) if (ram[DEPTH-1-k] !== mq[k]) imageOk = 0;
    check("backpressure_image", 32'(imageOk), 1);

    j0 = jenPulses; d0 = doneCount; r0 = rbDut.size();
    applyStimulus(0, 20, -1, -1, -1, 32'h0);
    checkOutput("starve", j0, d0, r0);

    d0 = doneCount;
    applyStimulus(2, -1, 33, -1, -1, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 32'(doneCount - d0), 0);
    check("abort_count_held", 32'(count), 33);

    j0 = jenPulses; d0 = doneCount; r0 = rbDut.size();
    applyStimulus(2, -1, -1, -1, -1, 32'hC000_0000);
    checkOutput("restore", j0, d0, r0);
    imageOk = 1;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 32'hC000_0000 + 32'(DEPTH - 1 - i)) imageOk = 0;
    check("restore_image", 32'(imageOk), 1);

    applyStimulus(0, -1, -1, 10, -1, 32'h0);
    check("post_reset_count", 32'(count), 0);

    j0 = jenPulses; d0 = doneCount; r0 = rbDut.size();
    applyStimulus(2, -1, -1, -1, 5, 32'h0);
    checkOutput("start_busy", j0, d0, r0);

    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    check("start_beats_abort", 32'(busy), 1);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("final_abort_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test expected finish before 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/jtag_ram_loader.md
Name: jtag_ram_loader

Overview:
- Upstream scan-chain controller for the 64-word JTAG RAM.
- Accepts a stream of program/data words over a valid/ready handshake and drives the RAM's Jen/Jin scan port, one word per shift.
- Returns each word shifted out of the chain's Jout as a readback stream, so one pass both loads a new image and dumps the old one.
- Sits between the host/debug link and the RAM; the normal Addr/Din/Wen port is untouched.

Parameters:
- DEPTH, 64, number of words in the scan chain; also the shift count of one pass.
- WIDTH, 32, word width of Jin/Jout and both streams.
- CW, 7, counter width; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a pass; sampled only in IDLE.
- abort  in  1  terminate the current pass immediately.
- in_valid  in  1  load word available.
- in_data  in  WIDTH  load word.
- in_ready  out  1  load word accepted this cycle when in_valid is also high.
- out_valid  out  1  readback word held in the output buffer.
- out_data  out  WIDTH  readback word.
- out_ready  in  1  consumer takes out_data this cycle.
- Jen  out  1  to RAM Jen; scan shift enable.
- Jin  out  WIDTH  to RAM Jin; head of the chain.
- Jout  in  WIDTH  from RAM Jout; tail of the chain.
- busy  out  1  high in SHIFT and DRAIN.
- done  out  1  one-cycle pulse at normal completion of a pass.
- count  out  CW  number of shifts completed in the current pass.

Behaviour:
- Reset (async, active-high) forces the following, independent of clk:
  - state=IDLE, count=0, out_valid=0, out_data=0, done=0, busy=0, Jen=0, in_ready=0.
  - Jin is combinational (equal to in_data) and is not reset.
- States: IDLE, SHIFT, DRAIN, FIN.
- IDLE:
  - in_ready=0, Jen=0.
  - start=1 -> SHIFT, count<=0.
  - abort in IDLE: no effect.
- SHIFT:
  - fire = in_valid & (~out_valid | out_ready).
  - in_ready = ~out_valid | out_ready; it does not depend on in_valid.
  - Jen = fire (combinational). Jin = in_data. The RAM shifts on the same edge.
  - On fire:
    - out_data <= Jout, the pre-shift tail word leaving the chain.
    - out_valid <= 1.
    - count <= count+1.
  - Fire with count==DEPTH-1 -> DRAIN.
- Output buffer (one entry, all states):
  - If out_valid & out_ready & ~fire: out_valid <= 0.
  - Simultaneous consume and fire: out_valid stays 1 with the new word (zero bubble).
  - Sustained throughput: 1 word/cycle when in_valid=out_ready=1.
  - Back-pressure: out_valid=1 with out_ready=0 stalls shifting (Jen=0). No word is ever lost or duplicated.
- DRAIN:
  - Jen=0, in_ready=0.
  - out_valid==0, or out_valid & out_ready -> FIN.
- FIN:
  - done=1 for exactly this cycle; busy=0; -> IDLE.
  - count holds DEPTH until the next start.
- Chain order: after a full pass of DEPTH shifts, the k-th accepted word (k=0..DEPTH-1) resides in the entry the k-th readback word came from. Readback order equals the chain's tail-first order.
- A full pass leaves the RAM holding exactly the loaded image; no partial rotation.
- abort in SHIFT or DRAIN:
  - Next state IDLE; out_valid <= 0 (pending readback discarded); done not pulsed.
  - count keeps its value to show progress.
  - Jen is 0 in the abort cycle even if fire conditions hold.
  - RAM is left rotated by count positions; recovery requires a new full pass.
- start while busy is ignored.
- start and abort together in IDLE: start wins.
- Reset mid-pass: immediate return to IDLE. The RAM contents are not touched by this block.

Test Plan:
- Full pass, no stalls: preload RAM entries with 0xA000_0000+i, start, in_data=0x5000_0000+k with in_valid=out_ready=1.
  - Exactly 64 Jen pulses in 64 consecutive cycles.
  - Readback sequence equals the old contents in tail-first order.
  - done pulses once, 2 cycles after the last fire.
  - Normal-port read of each address returns the new words.
- Back-pressure: same pass with out_ready toggling 1,0,0,1.
  - Jen never asserted while out_valid=1 & out_ready=0.
  - 64 readback words, no gaps or duplicates.
- Input starvation: in_valid low for 10 cycles at count=20.
  - Jen=0 and count=20 held throughout; pass completes normally.
- Abort: abort at count=33.
  - Next cycle state=IDLE, busy=0, out_valid=0, done never pulses, count=33.
  - A subsequent full pass restores a clean image.
- Async reset mid-pass at count=10, asserted between clock edges.
  - Outputs clear immediately without a clock edge.
  - After release, start begins a pass from count=0.
- start ignored while busy: pulse start at count=5.
  - Pass unaffected; total Jen pulses = 64.
